// File: rtl/hit_response_if.sv
// hit_response_if
// Groups the per-player hit-response signals into one bundle.
//   frame_tick   : one-cycle pulse per game frame
//   round_reset  : one-cycle pulse that starts a new round
//   hit_flag     : 00 none, 01 basic, 10 directional, 11 illegal
//   player_state : player FSM state, 4'd2 means blocking
//   stun_type    : 00 none, 01 hitstun, 10 blockstun, 11 KO
//   stun_frames  : remaining stun frames
//   health       : current health
//   hit_ack      : one-cycle pulse for each accepted hit
// The master modport is the side that produces the game inputs; the slave
// modport is the hit_response block itself.
interface hit_response_if;
    logic       frame_tick;
    logic       round_reset;
    logic [1:0] hit_flag;
    logic [3:0] player_state;
    logic [1:0] stun_type;
    logic [4:0] stun_frames;
    logic [6:0] health;
    logic       hit_ack;

    modport master (
        output frame_tick, round_reset, hit_flag, player_state,
        input  stun_type, stun_frames, health, hit_ack
    );

    modport slave (
        input  frame_tick, round_reset, hit_flag, player_state,
        output stun_type, stun_frames, health, hit_ack
    );
endinterface

// File: rtl/hit_response.sv
// hit_response
// Turns rising edges of the hit-detection flag into damage, stun and KO for
// one player.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : hit_response_if.slave (game inputs in, stun/health/ack out)
module hit_response #(
    parameter logic [6:0] MAX_HEALTH      = 7'd100,
    parameter logic [6:0] BASIC_DMG       = 7'd5,
    parameter logic [6:0] DIR_DMG         = 7'd10,
    parameter logic [6:0] CHIP_DMG        = 7'd1,
    parameter logic [4:0] BASIC_HITSTUN   = 5'd12,
    parameter logic [4:0] DIR_HITSTUN     = 5'd18,
    parameter logic [4:0] BASIC_BLOCKSTUN = 5'd6,
    parameter logic [4:0] DIR_BLOCKSTUN   = 5'd9
) (
    input logic         clk,
    input logic         rst_n,
    hit_response_if.slave bus
);

    // Encoding matches the stun_type output directly.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        HITSTUN   = 2'b01,
        BLOCKSTUN = 2'b10,
        KO        = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] frames_q, frames_d;
    logic [6:0] health_q, health_d;
    logic       ack_q, ack_d;
    logic [1:0] prev_flag;
    // Set once hit_flag has really been sampled after reset; the forced 00
    // in prev_flag during reset must not count as a sampled "no hit".
    logic       flag_sampled;

    logic       accept;
    logic       blocked;
    logic       basic;
    logic [7:0] dmg;
    logic [7:0] remain;

    // A hit is a fresh 01/10 edge seen while idle.
    assign basic   = (bus.hit_flag == 2'b01);
    assign blocked = (bus.player_state == 4'd2);
    assign accept  = (state_q == IDLE) && flag_sampled && (prev_flag == 2'b00) &&
                     ((bus.hit_flag == 2'b01) || (bus.hit_flag == 2'b10));

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frames_q     <= 5'd0;
            health_q     <= MAX_HEALTH;
            ack_q        <= 1'b0;
            prev_flag    <= 2'b00;
            flag_sampled <= 1'b0;
        end else begin
            state_q      <= state_d;
            frames_q     <= frames_d;
            health_q     <= health_d;
            ack_q        <= ack_d;
            prev_flag    <= bus.round_reset ? 2'b00 : bus.hit_flag;
            flag_sampled <= 1'b1;
        end
    end

    // Next-state logic. Round reset wins over hits and ticks; an accepted hit
    // wins over a tick (they cannot coincide, since accept needs IDLE).
    // Damage is worked out at 8 bits so a negative result shows up in bit 7
    // instead of wrapping; a zero-or-negative remainder means damage >= health.
    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        health_d = health_q;
        ack_d    = 1'b0;
        dmg      = 8'd0;
        remain   = 8'd0;
        if (bus.round_reset) begin
            state_d  = IDLE;
            frames_d = 5'd0;
            health_d = MAX_HEALTH;
        end else if (accept) begin
            ack_d = 1'b1;
            if (blocked) begin
                dmg      = {1'b0, CHIP_DMG};
                remain   = {1'b0, health_q} - dmg;
                state_d  = BLOCKSTUN;
                frames_d = basic ? BASIC_BLOCKSTUN : DIR_BLOCKSTUN;
                // Chip damage floors at 1 so blocking can never KO.
                health_d = (remain[7] || (remain == 8'd0)) ? 7'd1 : remain[6:0];
            end else begin
                dmg    = {1'b0, (basic ? BASIC_DMG : DIR_DMG)};
                remain = {1'b0, health_q} - dmg;
                if (remain[7] || (remain == 8'd0)) begin
                    state_d  = KO;
                    frames_d = 5'd0;
                    health_d = 7'd0;
                end else begin
                    state_d  = HITSTUN;
                    frames_d = basic ? BASIC_HITSTUN : DIR_HITSTUN;
                    health_d = remain[6:0];
                end
            end
        end else if (((state_q == HITSTUN) || (state_q == BLOCKSTUN)) && bus.frame_tick) begin
            // The tick that consumes the last frame also ends the stun.
            if (frames_q <= 5'd1) begin
                frames_d = 5'd0;
                state_d  = IDLE;
            end else begin
                frames_d = frames_q - 5'd1;
            end
        end
    end

    assign bus.stun_type   = 2'(state_q);
    assign bus.stun_frames = frames_q;
    assign bus.health      = health_q;
    assign bus.hit_ack     = ack_q;

endmodule

// File: tb/tb_hit_response.sv
// tb_hit_response
// Self-checking bench for hit_response: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the game rules.
module tb_hit_response;

    logic clk;
    logic rst_n;
    hit_response_if bus ();

    hit_response dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    // Behavioural model of one player's state, in plain integers.
    int m_health;
    int m_kind;      // 0 none, 1 hitstun, 2 blockstun, 3 KO
    int m_frames;
    int m_ack;
    int m_prev;
    int m_seen;      // at least one clock since reset has sampled the flag

    task automatic model_reset();
        m_health = 100;
        m_kind   = 0;
        m_frames = 0;
        m_ack    = 0;
        m_prev   = 0;
        m_seen   = 0;
    endtask

    // Game rules applied to the inputs present at one clock edge.
    task automatic model_update(input int flag, input int ps, input int tick, input int rr);
        int dmg;
        m_ack = 0;
        if (rr != 0) begin
            m_kind   = 0;
            m_frames = 0;
            m_health = 100;
            m_prev   = 0;
        end else begin
            if (m_kind == 0 && m_seen != 0 && m_prev == 0 && (flag == 1 || flag == 2)) begin
                m_ack = 1;
                if (ps == 2) begin
                    m_health = (m_health - 1 < 1) ? 1 : m_health - 1;
                    m_kind   = 2;
                    m_frames = (flag == 1) ? 6 : 9;
                end else begin
                    dmg = (flag == 1) ? 5 : 10;
                    if (dmg >= m_health) begin
                        m_health = 0;
                        m_kind   = 3;
                        m_frames = 0;
                    end else begin
                        m_health = m_health - dmg;
                        m_kind   = 1;
                        m_frames = (flag == 1) ? 12 : 18;
                    end
                end
            end else if ((m_kind == 1 || m_kind == 2) && tick != 0) begin
                m_frames = m_frames - 1;
                if (m_frames == 0) m_kind = 0;
            end
            m_prev = flag;
        end
        m_seen = 1;
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge
    // happen, update the model, and return at the next falling edge.
    task automatic step(input logic [1:0] flag, input logic [3:0] ps,
                        input logic tick, input logic rr);
        bus.hit_flag     = flag;
        bus.player_state = ps;
        bus.frame_tick   = tick;
        bus.round_reset  = rr;
        @(posedge clk);
        if (rst_n) model_update(int'(flag), int'(ps), int'(tick), int'(rr));
        @(negedge clk);
    endtask

    // Lands a hit from IDLE and ticks until the block is idle again.
    task automatic do_hit(input logic [1:0] flag, input logic [3:0] ps);
        int n;
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(flag, ps, 1'b0, 1'b0);
        n = 0;
        while (bus.stun_type != 2'b00 && n < 40) begin
            step(2'b00, 4'd0, 1'b1, 1'b0);
            n++;
        end
        checks++;
        if (bus.stun_type !== 2'b00) $display("[TB] FAIL recover_timeout stun_type=%b required 00", bus.stun_type);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.hit_flag     = 2'b01;
        bus.player_state = 4'd0;
        bus.frame_tick   = 1'b0;
        bus.round_reset  = 1'b0;
        model_reset();
        #12;
        checks++; if (bus.stun_type !== 2'b00) $display("[TB] FAIL reset_type got %b need 00", bus.stun_type); else passes++;
        checks++; if (bus.stun_frames !== 5'd0) $display("[TB] FAIL reset_frames got %0d need 0", bus.stun_frames); else passes++;
        checks++; if (bus.health !== 7'd100) $display("[TB] FAIL reset_health got %0d need 100", bus.health); else passes++;
        checks++; if (bus.hit_ack !== 1'b0) $display("[TB] FAIL reset_ack got %b need 0", bus.hit_ack); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        // Flag already high at release: not a fresh edge.
        step(2'b01, 4'd0, 1'b0, 1'b0);
        checks++; if (bus.hit_ack !== 1'b0 || bus.stun_type !== 2'b00) $display("[TB] FAIL post_reset_held ack=%b type=%b need 0/00", bus.hit_ack, bus.stun_type); else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b01, 4'd0, 1'b0, 1'b0);
        checks++; if (bus.hit_ack !== 1'b1 || bus.health !== 7'd95) $display("[TB] FAIL post_reset_edge ack=%b health=%0d need 1/95", bus.hit_ack, bus.health); else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_basic_hit();
        int acks, ticks, idle_at;
        step(2'b00, 4'd0, 1'b0, 1'b1);
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b01, 4'd0, 1'b0, 1'b0);
        checks++; if (bus.hit_ack !== 1'b1) $display("[TB] FAIL basic_ack got %b need 1", bus.hit_ack); else passes++;
        checks++; if (bus.stun_type !== 2'b01) $display("[TB] FAIL basic_type got %b need 01", bus.stun_type); else passes++;
        checks++; if (bus.stun_frames !== 5'd12) $display("[TB] FAIL basic_frames got %0d need 12", bus.stun_frames); else passes++;
        checks++; if (bus.health !== 7'd95) $display("[TB] FAIL basic_health got %0d need 95", bus.health); else passes++;
        acks = 0; ticks = 0; idle_at = -1;
        for (int i = 0; i < 39; i++) begin
            step(2'b01, 4'd0, (i % 3 == 0), 1'b0);
            if (i % 3 == 0) ticks++;
            if (bus.hit_ack === 1'b1) acks++;
            if (idle_at < 0 && bus.stun_type === 2'b00) idle_at = ticks;
        end
        checks++; if (acks != 0) $display("[TB] FAIL basic_single_ack extra acks %0d need 0", acks); else passes++;
        checks++; if (idle_at != 12) $display("[TB] FAIL basic_stun_len idle after %0d ticks need 12", idle_at); else passes++;
        checks++; if (bus.stun_frames !== 5'd0 || bus.health !== 7'd95) $display("[TB] FAIL basic_end frames=%0d health=%0d need 0/95", bus.stun_frames, bus.health); else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_blocked_hit();
        int ticks;
        step(2'b00, 4'd0, 1'b0, 1'b1);
        step(2'b00, 4'd2, 1'b0, 1'b0);
        step(2'b10, 4'd2, 1'b0, 1'b0);
        checks++; if (bus.stun_type !== 2'b10 || bus.stun_frames !== 5'd9 || bus.health !== 7'd99)
            $display("[TB] FAIL block_load type=%b frames=%0d health=%0d need 10/9/99", bus.stun_type, bus.stun_frames, bus.health);
        else passes++;
        ticks = 0;
        while (bus.stun_type !== 2'b00 && ticks < 30) begin
            step(2'b00, 4'd0, 1'b1, 1'b0);
            ticks++;
        end
        checks++; if (ticks != 9) $display("[TB] FAIL block_stun_len got %0d ticks need 9", ticks); else passes++;
    endtask

    task automatic test_ko();
        int acks;
        step(2'b00, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) do_hit(2'b10, 4'd0);
        do_hit(2'b01, 4'd2);
        do_hit(2'b01, 4'd2);
        checks++; if (bus.health !== 7'd8) $display("[TB] FAIL ko_setup health=%0d need 8", bus.health); else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b10, 4'd0, 1'b0, 1'b0);
        checks++; if (bus.health !== 7'd0 || bus.stun_type !== 2'b11 || bus.stun_frames !== 5'd0 || bus.hit_ack !== 1'b1)
            $display("[TB] FAIL ko_enter health=%0d type=%b frames=%0d ack=%b need 0/11/0/1", bus.health, bus.stun_type, bus.stun_frames, bus.hit_ack);
        else passes++;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? 2'b00 : 2'b01, (i > 4) ? 4'd2 : 4'd0, 1'b1, 1'b0);
            if (bus.hit_ack === 1'b1) acks++;
        end
        checks++; if (acks != 0 || bus.stun_type !== 2'b11 || bus.health !== 7'd0)
            $display("[TB] FAIL ko_hold acks=%0d type=%b health=%0d need 0/11/0", acks, bus.stun_type, bus.health);
        else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
        // Round reset arrives together with a hit edge and a tick.
        step(2'b01, 4'd0, 1'b1, 1'b1);
        checks++; if (bus.health !== 7'd100 || bus.stun_type !== 2'b00 || bus.stun_frames !== 5'd0 || bus.hit_ack !== 1'b0)
            $display("[TB] FAIL round_reset health=%0d type=%b frames=%0d ack=%b need 100/00/0/0", bus.health, bus.stun_type, bus.stun_frames, bus.hit_ack);
        else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_chip_floor();
        step(2'b00, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) do_hit(2'b10, 4'd0);
        do_hit(2'b01, 4'd0);
        for (int i = 0; i < 4; i++) do_hit(2'b01, 4'd2);
        checks++; if (bus.health !== 7'd1) $display("[TB] FAIL chip_setup health=%0d need 1", bus.health); else passes++;
        step(2'b00, 4'd2, 1'b0, 1'b0);
        step(2'b01, 4'd2, 1'b0, 1'b0);
        checks++; if (bus.health !== 7'd1 || bus.stun_type !== 2'b10 || bus.stun_frames !== 5'd6)
            $display("[TB] FAIL chip_floor health=%0d type=%b frames=%0d need 1/10/6", bus.health, bus.stun_type, bus.stun_frames);
        else passes++;
        for (int i = 0; i < 6; i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        checks++; if (bus.stun_type !== 2'b00) $display("[TB] FAIL chip_recover type=%b need 00", bus.stun_type); else passes++;
    endtask

    task automatic test_expiry_collision();
        step(2'b00, 4'd0, 1'b0, 1'b1);
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b01, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        checks++; if (bus.stun_frames !== 5'd1) $display("[TB] FAIL collide_setup frames=%0d need 1", bus.stun_frames); else passes++;
        step(2'b01, 4'd0, 1'b1, 1'b0);
        checks++; if (bus.stun_type !== 2'b00 || bus.hit_ack !== 1'b0 || bus.health !== 7'd95 || bus.stun_frames !== 5'd0)
            $display("[TB] FAIL collide type=%b ack=%b health=%0d frames=%0d need 00/0/95/0", bus.stun_type, bus.hit_ack, bus.health, bus.stun_frames);
        else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b11, 4'd0, 1'b0, 1'b0);
        checks++; if (bus.stun_type !== 2'b00 || bus.hit_ack !== 1'b0 || bus.health !== 7'd95)
            $display("[TB] FAIL illegal_flag type=%b ack=%b health=%0d need 00/0/95", bus.stun_type, bus.hit_ack, bus.health);
        else passes++;
        step(2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        step(2'b00, 4'd0, 1'b0, 1'b1);
        step(2'b00, 4'd0, 1'b0, 1'b0);
        step(2'b01, 4'd0, 1'b0, 1'b0);
        step(2'b00, 4'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.stun_type !== 2'b00 || bus.stun_frames !== 5'd0 || bus.health !== 7'd100 || bus.hit_ack !== 1'b0)
            $display("[TB] FAIL async_reset type=%b frames=%0d health=%0d ack=%b need 00/0/100/0", bus.stun_type, bus.stun_frames, bus.health, bus.hit_ack);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] f;
        logic [3:0] ps;
        logic       t, rr;
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            f  = 2'($urandom_range(0, 3));
            ps = ($urandom_range(0, 2) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
            t  = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 99) == 0);
            step(f, ps, t, rr);
            checks++;
            if ({bus.stun_type, bus.stun_frames, bus.health, bus.hit_ack} !==
                {2'(m_kind), 5'(m_frames), 7'(m_health), 1'(m_ack)}) begin
                if (errs < 10)
                    $display("[TB] FAIL random cycle %0d got type=%b frames=%0d health=%0d ack=%b need %0d/%0d/%0d/%0d",
                             i, bus.stun_type, bus.stun_frames, bus.health, bus.hit_ack, m_kind, m_frames, m_health, m_ack);
                errs++;
            end else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_blocked_hit();
        test_ko();
        test_chip_floor();
        test_expiry_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
